// File: rtl/spi_cmd_pkg.sv
// Shared constants, R/W encoding and FSM state type for the SPI command initiator.
package spi_cmd_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int HDR_BITS       = 1 + DEF_ADDR_WIDTH;
  localparam int FRAME_BITS     = HDR_BITS + DEF_DATA_WIDTH;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_SHIFT = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_ISSUE    = 3'd5,
    ST_DRAIN    = 3'd6
  } spi_cmd_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus registered edge pulses, all aligned
// so that pulses, cs_n_sync and mosi_sync describe the same clk cycle.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_pin,
  input  logic cs_n_pin,
  input  logic mosi_pin,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_n_sync,
  output logic mosi_sync
);

  logic [1:0] sclk_meta_r;
  logic [1:0] cs_meta_r;
  logic [1:0] mosi_meta_r;
  logic       sclk_d_r;

  // Synchronize pins and detect edges; CS resets low so a frame already running
  // at reset release never produces a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_r <= 2'b00;
      cs_meta_r   <= 2'b00;
      mosi_meta_r <= 2'b00;
      sclk_d_r    <= 1'b0;
      cs_n_sync   <= 1'b0;
      mosi_sync   <= 1'b0;
      sclk_rise   <= 1'b0;
      sclk_fall   <= 1'b0;
      cs_fall     <= 1'b0;
      cs_rise     <= 1'b0;
    end else begin
      sclk_meta_r <= {sclk_meta_r[0], sclk_pin};
      cs_meta_r   <= {cs_meta_r[0], cs_n_pin};
      mosi_meta_r <= {mosi_meta_r[0], mosi_pin};
      sclk_d_r    <= sclk_meta_r[1];
      cs_n_sync   <= cs_meta_r[1];
      mosi_sync   <= mosi_meta_r[1];
      sclk_rise   <= sclk_meta_r[1] & ~sclk_d_r;
      sclk_fall   <= ~sclk_meta_r[1] & sclk_d_r;
      cs_fall     <= ~cs_meta_r[1] & cs_n_sync;
      cs_rise     <= cs_meta_r[1] & ~cs_n_sync;
    end
  end

endmodule

// File: rtl/spi_cmd_initiator.sv
// SPI-slave front end: decodes R/W + address + data frames into single-beat
// commands and returns read data on MISO within the same frame.
module spi_cmd_initiator
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  cmd_valid,
  output logic                  cmd_write,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_rdata,
  input  logic                  mem_busy,
  output logic                  frame_err,
  output logic                  resp_late
);

  localparam int HDR_LEN = 1 + ADDR_WIDTH;
  localparam int FRM_LEN = HDR_LEN + DATA_WIDTH;

  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s, cs_n_s, mosi_s;

  spi_pin_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk_pin  (spi_sclk),
    .cs_n_pin  (spi_cs_n),
    .mosi_pin  (spi_mosi),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .cs_fall   (cs_fall_s),
    .cs_rise   (cs_rise_s),
    .cs_n_sync (cs_n_s),
    .mosi_sync (mosi_s)
  );

  spi_cmd_state_e        state_r;
  logic [5:0]            bit_cnt_r;
  logic [5:0]            out_cnt_r;
  logic [DATA_WIDTH-2:0] shift_in_r;
  logic [DATA_WIDTH-1:0] shift_out_r;
  logic [ADDR_WIDTH-1:0] pend_addr_r;
  logic [DATA_WIDTH-1:0] pend_wdata_r;
  logic                  issued_r;
  logic [DATA_WIDTH-1:0] shift_nxt_s;

  // Header fields sit in the low bits at the 8th edge; data fills all bits at the 32nd.
  assign shift_nxt_s = {shift_in_r, mosi_s};

  // Frame FSM, bit counting and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 6'd0;
      out_cnt_r    <= 6'd0;
      shift_in_r   <= '0;
      shift_out_r  <= '0;
      pend_addr_r  <= '0;
      pend_wdata_r <= '0;
      issued_r     <= 1'b0;
      spi_miso     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      frame_err    <= 1'b0;
      resp_late    <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      resp_late <= 1'b0;
      if (cs_n_s) begin
        bit_cnt_r <= 6'd0;
      end else if (sclk_rise_s && bit_cnt_r != 6'(FRM_LEN)) begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end
      if (sclk_rise_s) begin
        shift_in_r <= shift_nxt_s[DATA_WIDTH-2:0];
      end
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) state_r <= ST_HDR;
        end
        ST_HDR: begin
          if (cs_rise_s) begin
            frame_err <= 1'b1;
            state_r   <= ST_IDLE;
          end else if (sclk_rise_s && bit_cnt_r == 6'(HDR_LEN - 1)) begin
            pend_addr_r <= shift_nxt_s[ADDR_WIDTH-1:0];
            if (shift_nxt_s[ADDR_WIDTH] == RW_WRITE) begin
              state_r <= ST_WR_DATA;
            end else begin
              state_r  <= ST_RD_WAIT;
              issued_r <= !mem_busy;
              if (!mem_busy) begin
                cmd_valid <= 1'b1;
                cmd_write <= RW_READ;
                cmd_addr  <= shift_nxt_s[ADDR_WIDTH-1:0];
                cmd_wdata <= '0;
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (cs_rise_s) begin
            frame_err <= 1'b1;
            state_r   <= ST_IDLE;
          end else if (sclk_rise_s && bit_cnt_r == 6'(FRM_LEN - 1)) begin
            pend_wdata_r <= shift_nxt_s;
            if (!mem_busy) begin
              cmd_valid <= 1'b1;
              cmd_write <= RW_WRITE;
              cmd_addr  <= pend_addr_r;
              cmd_wdata <= shift_nxt_s;
              state_r   <= ST_DRAIN;
            end else begin
              state_r <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // A latched write is committed even if CS_n has already risen.
          if (!mem_busy) begin
            cmd_valid <= 1'b1;
            cmd_write <= RW_WRITE;
            cmd_addr  <= pend_addr_r;
            cmd_wdata <= pend_wdata_r;
            state_r   <= ST_DRAIN;
          end
        end
        ST_RD_WAIT: begin
          if (cs_rise_s) begin
            state_r <= ST_IDLE;
          end else if (sclk_fall_s) begin
            // First data-phase falling edge: data must be on MISO now or never.
            if (issued_r && resp_valid) begin
              spi_miso    <= resp_rdata[DATA_WIDTH-1];
              shift_out_r <= {resp_rdata[DATA_WIDTH-2:0], 1'b0};
            end else begin
              spi_miso    <= 1'b0;
              shift_out_r <= '0;
              resp_late   <= 1'b1;
            end
            out_cnt_r <= 6'd1;
            state_r   <= ST_RD_SHIFT;
          end else if (!issued_r && !mem_busy) begin
            cmd_valid <= 1'b1;
            cmd_write <= RW_READ;
            cmd_addr  <= pend_addr_r;
            cmd_wdata <= '0;
            issued_r  <= 1'b1;
          end else if (issued_r && resp_valid) begin
            shift_out_r <= resp_rdata;
            out_cnt_r   <= 6'd0;
            state_r     <= ST_RD_SHIFT;
          end
        end
        ST_RD_SHIFT: begin
          if (cs_rise_s) begin
            spi_miso <= 1'b0;
            state_r  <= ST_IDLE;
          end else if (sclk_fall_s) begin
            if (out_cnt_r == 6'(DATA_WIDTH)) begin
              spi_miso <= 1'b0;
              state_r  <= ST_DRAIN;
            end else begin
              spi_miso    <= shift_out_r[DATA_WIDTH-1];
              shift_out_r <= {shift_out_r[DATA_WIDTH-2:0], 1'b0};
              out_cnt_r   <= out_cnt_r + 6'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (cs_n_s) state_r <= ST_IDLE;
        end
        default: begin
          spi_miso <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
